// File: rtl/tc_ps_acp_tx.sv
// tc_ps_acp_tx
//   AXI3 write master for the PS ACP port (S_AXI_ACP_0 AW/W/B channels).
//   It accepts a command made of a start address and a count of 64-bit
//   words, then drains a valid/ready 64-bit data stream into coherent
//   memory. The words go out as INCR bursts of up to MAX_BURST beats, and
//   only one burst is outstanding at a time. No burst crosses a 4 KB
//   boundary.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   cmd_valid/cmd_ready          command handshake (ready only while idle)
//   cmd_addr[31:0], cmd_len[15:0] start byte address (8-byte aligned by
//                                forcing bits[2:0] to 0), word count (0 = no-op)
//   din_valid/din_ready/din_data write-data stream
//   busy, done, err              status: in-flight, completion pulse,
//                                sticky write-error for the current command
//   S_AXI_ACP_0_aw*/w*/b*        AXI3 write-address, write-data and
//                                write-response channels
module tc_ps_acp_tx #(
  parameter int unsigned MAX_BURST = 16,
  parameter logic [2:0]  AXI_ID    = 3'd0,
  parameter logic [3:0]  ACP_CACHE = 4'hF,
  parameter logic [4:0]  ACP_USER  = 5'h01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [15:0] cmd_len,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic [63:0] din_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] S_AXI_ACP_0_awaddr,
  output logic [1:0]  S_AXI_ACP_0_awburst,
  output logic [3:0]  S_AXI_ACP_0_awcache,
  output logic [2:0]  S_AXI_ACP_0_awid,
  output logic [3:0]  S_AXI_ACP_0_awlen,
  output logic [1:0]  S_AXI_ACP_0_awlock,
  output logic [2:0]  S_AXI_ACP_0_awprot,
  output logic [3:0]  S_AXI_ACP_0_awqos,
  output logic [2:0]  S_AXI_ACP_0_awsize,
  output logic [4:0]  S_AXI_ACP_0_awuser,
  output logic        S_AXI_ACP_0_awvalid,
  input  logic        S_AXI_ACP_0_awready,
  output logic [63:0] S_AXI_ACP_0_wdata,
  output logic [2:0]  S_AXI_ACP_0_wid,
  output logic        S_AXI_ACP_0_wlast,
  output logic [7:0]  S_AXI_ACP_0_wstrb,
  output logic        S_AXI_ACP_0_wvalid,
  input  logic        S_AXI_ACP_0_wready,
  input  logic [2:0]  S_AXI_ACP_0_bid,
  input  logic [1:0]  S_AXI_ACP_0_bresp,
  input  logic        S_AXI_ACP_0_bvalid,
  output logic        S_AXI_ACP_0_bready
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t      state_r;
  logic [31:0] addr_r;
  logic [15:0] rem_r;
  logic [4:0]  beats_r;
  logic [3:0]  beat_cnt_r;
  logic [31:0] awaddr_r;
  logic [3:0]  awlen_r;
  logic        awvalid_r;
  logic        w_active_r;
  logic        wlast_r;
  logic        bready_r;
  logic        cmd_ready_r;
  logic        busy_r;
  logic        done_r;
  logic        err_r;

  logic [4:0]  cap_s;
  logic [12:0] room_s;
  logic [4:0]  beats_s;
  logic [15:0] rem_next_s;
  logic        unused_s;

  // bid is not checked (single ID) and the low address bits are forced to 0.
  assign unused_s = ^{S_AXI_ACP_0_bid, cmd_addr[2:0]};

  // Burst sizing: limited by the remaining words, MAX_BURST and the words left before the next 4 KB page.
  always_comb begin
    cap_s      = (rem_r > 16'(MAX_BURST)) ? 5'(MAX_BURST) : rem_r[4:0];
    room_s     = (13'h1000 - {1'b0, addr_r[11:0]}) >> 3;
    beats_s    = ({8'd0, cap_s} > room_s) ? room_s[4:0] : cap_s;
    rem_next_s = rem_r - {11'd0, beats_r};
  end

  // Command sequencing: AW issue, W beat counting, B collection and completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      addr_r      <= 32'd0;
      rem_r       <= 16'd0;
      beats_r     <= 5'd0;
      beat_cnt_r  <= 4'd0;
      awaddr_r    <= 32'd0;
      awlen_r     <= 4'd0;
      awvalid_r   <= 1'b0;
      w_active_r  <= 1'b0;
      wlast_r     <= 1'b0;
      bready_r    <= 1'b0;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready_r) begin
            addr_r      <= {cmd_addr[31:3], 3'b000};
            rem_r       <= cmd_len;
            err_r       <= 1'b0;
            busy_r      <= 1'b1;
            cmd_ready_r <= 1'b0;
            state_r     <= (cmd_len == 16'd0) ? ST_DONE : ST_AW;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_AW: begin
          // First AW cycle loads the burst; awvalid then holds until accepted.
          if (!awvalid_r) begin
            awaddr_r  <= addr_r;
            awlen_r   <= beats_s[3:0] - 4'd1;
            beats_r   <= beats_s;
            awvalid_r <= 1'b1;
          end else if (S_AXI_ACP_0_awready) begin
            awvalid_r  <= 1'b0;
            beat_cnt_r <= 4'd0;
            wlast_r    <= (awlen_r == 4'd0);
            w_active_r <= 1'b1;
            state_r    <= ST_W;
          end else begin
            awvalid_r <= 1'b1;
          end
        end
        ST_W: begin
          if (din_valid && S_AXI_ACP_0_wready) begin
            if (wlast_r) begin
              wlast_r    <= 1'b0;
              w_active_r <= 1'b0;
              bready_r   <= 1'b1;
              state_r    <= ST_B;
            end else begin
              beat_cnt_r <= beat_cnt_r + 4'd1;
              wlast_r    <= ((beat_cnt_r + 4'd1) == awlen_r);
            end
          end else begin
            state_r <= ST_W;
          end
        end
        ST_B: begin
          if (S_AXI_ACP_0_bvalid) begin
            bready_r <= 1'b0;
            err_r    <= err_r | (S_AXI_ACP_0_bresp != 2'b00);
            addr_r   <= addr_r + {24'd0, beats_r, 3'b000};
            rem_r    <= rem_next_s;
            state_r  <= (rem_next_s == 16'd0) ? ST_DONE : ST_AW;
          end else begin
            state_r <= ST_B;
          end
        end
        ST_DONE: begin
          done_r      <= 1'b1;
          busy_r      <= 1'b0;
          cmd_ready_r <= 1'b1;
          state_r     <= ST_IDLE;
        end
        default: begin
          state_r     <= ST_IDLE;
          awvalid_r   <= 1'b0;
          w_active_r  <= 1'b0;
          wlast_r     <= 1'b0;
          bready_r    <= 1'b0;
          busy_r      <= 1'b0;
          cmd_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;

  assign S_AXI_ACP_0_awaddr  = awaddr_r;
  assign S_AXI_ACP_0_awburst = 2'b01;
  assign S_AXI_ACP_0_awcache = ACP_CACHE;
  assign S_AXI_ACP_0_awid    = AXI_ID;
  assign S_AXI_ACP_0_awlen   = awlen_r;
  assign S_AXI_ACP_0_awlock  = 2'b00;
  assign S_AXI_ACP_0_awprot  = 3'b000;
  assign S_AXI_ACP_0_awqos   = 4'b0000;
  assign S_AXI_ACP_0_awsize  = 3'b011;
  assign S_AXI_ACP_0_awuser  = ACP_USER;
  assign S_AXI_ACP_0_awvalid = awvalid_r;

  // The data path is a pass-through so that the stream adds no latency; the gate is a register.
  assign S_AXI_ACP_0_wdata  = din_data;
  assign S_AXI_ACP_0_wid    = AXI_ID;
  assign S_AXI_ACP_0_wlast  = wlast_r;
  assign S_AXI_ACP_0_wstrb  = 8'hFF;
  assign S_AXI_ACP_0_wvalid = w_active_r & din_valid;
  assign din_ready          = w_active_r & S_AXI_ACP_0_wready;

  assign S_AXI_ACP_0_bready = bready_r;

endmodule
